// File: rtl/seq_calc_unit.sv
// seq_calc_unit: start/done add, sub, shift-add mul and restoring div.
// Optional macro CALC_SAT_EN clamps add overflow and sub underflow.
module seq_calc_unit #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     rem,
    output logic                 carry,
    output logic                 div_zero
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t             state, nstate;
    logic [WIDTH-1:0]   ra, rb, mq;
    logic [1:0]         rop;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0] madd, dsh, dsub, asum, adif;

    assign madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mq[0] ? ra : '0};
    assign dsh  = {acc[2*WIDTH-1:WIDTH], mq[WIDTH-1]};
    assign dsub = dsh - {1'b0, rb};
    assign asum = {1'b0, ra} + {1'b0, rb};
    assign adif = {1'b0, ra} - {1'b0, rb};
    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state selection
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    unique case (op)
                        2'b10:   nstate = MUL;
                        2'b11:   nstate = (b == '0) ? FIN : DIV;
                        default: nstate = FIN;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt == CNT_W'(1)) nstate = FIN;
            end
            default: nstate = IDLE;
        endcase
    end

    // Operand capture, iterative datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra       <= '0;
            rb       <= '0;
            mq       <= '0;
            rop      <= '0;
            acc      <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            result   <= '0;
            rem      <= '0;
            carry    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ra       <= a;
                        rb       <= b;
                        rop      <= op;
                        acc      <= '0;
                        mq       <= (op == 2'b10) ? b : a;
                        cnt      <= CNT_W'(WIDTH);
                        div_zero <= (op == 2'b11) && (b == '0);
                    end
                end
                MUL: begin
                    acc <= {madd, acc[WIDTH-1:1]};
                    mq  <= mq >> 1;
                    cnt <= cnt - 1'b1;
                end
                DIV: begin
                    acc[2*WIDTH-1:WIDTH] <= dsub[WIDTH] ? dsh[WIDTH-1:0]
                                                        : dsub[WIDTH-1:0];
                    mq  <= {mq[WIDTH-2:0], ~dsub[WIDTH]};
                    cnt <= cnt - 1'b1;
                end
                default: begin
                    done <= 1'b1;
                    unique case (rop)
                        2'b00: begin
`ifdef CALC_SAT_EN
                            result <= asum[WIDTH]
                                ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                : {{(WIDTH-1){1'b0}}, asum};
`else
                            result <= {{(WIDTH-1){1'b0}}, asum};
`endif
                            rem    <= '0;
                            carry  <= asum[WIDTH];
                        end
                        2'b01: begin
`ifdef CALC_SAT_EN
                            result <= adif[WIDTH] ? '0
                                : {{(WIDTH-1){1'b0}}, adif};
`else
                            result <= {{(WIDTH-1){1'b0}}, adif};
`endif
                            rem    <= '0;
                            carry  <= adif[WIDTH];
                        end
                        2'b10: begin
                            result <= acc;
                            rem    <= '0;
                            carry  <= 1'b0;
                        end
                        default: begin
                            if (div_zero) begin
                                result <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                rem    <= ra;
                            end else begin
                                result <= {{WIDTH{1'b0}}, mq};
                                rem    <= acc[2*WIDTH-1:WIDTH];
                            end
                            carry <= 1'b0;
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calc_unit.sv
// tb_seq_calc_unit: directed and random checks of seq_calc_unit
// against an arithmetic reference model.
module tb_seq_calc_unit;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     op = '0;
    logic [W-1:0]   a = '0, b = '0;
    logic           busy, done, carry, div_zero;
    logic [2*W-1:0] result;
    logic [W-1:0]   rem;

    int checks = 0;
    int errors = 0;

    seq_calc_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .rem(rem), .carry(carry), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic from the operation definitions
    task automatic model(input logic [1:0] o, input int x, input int y,
                         output logic [2*W-1:0] er, output logic [W-1:0] erem,
                         output logic ec, output logic edz, output int elat);
        er = '0; erem = '0; ec = 1'b0; edz = 1'b0; elat = 1;
        case (o)
            2'd0: begin
                ec = (x + y) >= (1 << W);
                er = (2*W)'(x + y);
`ifdef CALC_SAT_EN
                if (ec) er = (2*W)'((1 << W) - 1);
`endif
            end
            2'd1: begin
                ec = x < y;
                er = ec ? (2*W)'(x - y + (1 << (W + 1))) : (2*W)'(x - y);
`ifdef CALC_SAT_EN
                if (ec) er = '0;
`endif
            end
            2'd2: begin
                er = (2*W)'(x * y);
                elat = W + 1;
            end
            default: begin
                if (y == 0) begin
                    er = (2*W)'((1 << W) - 1);
                    erem = W'(x);
                    edz = 1'b1;
                end else begin
                    er = (2*W)'(x / y);
                    erem = W'(x % y);
                    elat = W + 1;
                end
            end
        endcase
    endtask

    // Issue one command, then scramble inputs; return latency and busy cycles
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, output int lat, output int bc);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 0;
        bc = busy ? 1 : 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy) bc++;
        end
        if (!done) lat = -1;
    endtask

    task automatic run_check(input string name, input logic [1:0] o,
                             input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] er;
        logic [W-1:0]   erem;
        logic           ec, edz;
        int             elat, lat, bc;
        model(o, int'(x), int'(y), er, erem, ec, edz, elat);
        issue(o, x, y, lat, bc);
        checks++;
        if (result !== er || rem !== erem || carry !== ec ||
            div_zero !== edz || lat != elat || bc != elat || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s op=%0d a=%0d b=%0d: got res=%h rem=%h c=%b dz=%b lat=%0d busy_cyc=%0d busy=%b want res=%h rem=%h c=%b dz=%b lat=%0d busy_cyc=%0d busy=0",
                     name, o, x, y, result, rem, carry, div_zero, lat, bc, busy,
                     er, erem, ec, edz, elat, elat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, rem, carry, div_zero} !== '0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b res=%h rem=%h c=%b dz=%b want all 0",
                     busy, done, result, rem, carry, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        run_check("add_9_8", 2'd0, 4'd9, 4'd8);
        run_check("add_15_15", 2'd0, 4'd15, 4'd15);
        run_check("add_3_4", 2'd0, 4'd3, 4'd4);
    endtask

    task automatic test_sub();
        run_check("sub_3_5", 2'd1, 4'd3, 4'd5);
        run_check("sub_5_3", 2'd1, 4'd5, 4'd3);
        run_check("sub_0_15", 2'd1, 4'd0, 4'd15);
    endtask

    task automatic test_mul();
        run_check("mul_15_15", 2'd2, 4'd15, 4'd15);
        run_check("mul_0_7", 2'd2, 4'd0, 4'd7);
        run_check("mul_6_11", 2'd2, 4'd6, 4'd11);
    endtask

    task automatic test_div();
        run_check("div_13_4", 2'd3, 4'd13, 4'd4);
        run_check("div_9_0", 2'd3, 4'd9, 4'd0);
        run_check("div_15_1", 2'd3, 4'd15, 4'd1);
        run_check("div_3_7", 2'd3, 4'd3, 4'd7);
        run_check("add_after_dz", 2'd0, 4'd1, 4'd2);
    endtask

    task automatic test_ignore_busy();
        int ndone = 0;
        logic [2*W-1:0] last = '0;
        @(negedge clk);
        op = 2'd2; a = 4'd15; b = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = 2'd0; a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                last = result;
            end
        end
        checks++;
        if (ndone != 1 || last !== 8'hE1) begin
            errors++;
            $display("FAIL ignore_busy: got dones=%0d res=%h want dones=1 res=e1",
                     ndone, last);
        end
    endtask

    task automatic test_back_to_back();
        run_check("b2b_mul", 2'd2, 4'd5, 4'd3);
        run_check("b2b_add", 2'd0, 4'd7, 4'd6);
        run_check("b2b_div", 2'd3, 4'd14, 4'd3);
        run_check("b2b_sub", 2'd1, 4'd2, 4'd9);
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        @(negedge clk);
        op = 2'd3; a = 4'd13; b = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, rem, carry, div_zero} !== '0) begin
            errors++;
            $display("FAIL reset_abort: got busy=%b done=%b res=%h rem=%h c=%b dz=%b want all 0",
                     busy, done, result, rem, carry, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d cycles with done/busy want 0", ndone);
        end
        run_check("post_reset_div", 2'd3, 4'd13, 4'd4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_check("random", 2'($urandom), W'($urandom),
                      W'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
